// File: rtl/tetris_pkg.sv
// ----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the Tetris board datapath: board geometry, the
// line_clear_unit state encoding, the per-clear score table and small helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package tetris_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int BOARD_BITS = 200;

  typedef logic [BOARD_BITS-1:0] board_t;
  typedef logic [BOARD_COLS-1:0] row_t;
  typedef logic [BOARD_ROWS-1:0] row_mask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLASH,
    ST_COLLAPSE,
    ST_ZERO,
    ST_DONE
  } lcu_state_t;

  // Points awarded for 0/1/2/3/4 lines cleared by a single lock.
  localparam logic [15:0] SCORE_0 = 16'd0;
  localparam logic [15:0] SCORE_1 = 16'd1;
  localparam logic [15:0] SCORE_2 = 16'd3;
  localparam logic [15:0] SCORE_3 = 16'd5;
  localparam logic [15:0] SCORE_4 = 16'd8;

  // A single locked piece spans at most 4 rows, so the count fits in 3 bits.
  function automatic logic [2:0] popcount_rows(input row_mask_t m);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < BOARD_ROWS; i++) begin
      n = n + 5'(m[i]);
    end
    return n[2:0];
  endfunction

  function automatic logic [15:0] score_for_lines(input logic [2:0] n);
    case (n)
      3'd0:    return SCORE_0;
      3'd1:    return SCORE_1;
      3'd2:    return SCORE_2;
      3'd3:    return SCORE_3;
      default: return SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/frame_blink_timer.sv
// ----------------------------------------------------------------------------
// frame_blink_timer
// Counts video frame ticks during the flash phase. Produces the blink phase
// (1 on entry, toggling every BLINK_FRAMES ticks) and an expiry strobe on the
// FLASH_FRAMES-th tick.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_clear        : restart counters, phase forced to 1 (flash entry)
//   i_en           : ticks are counted only while high
//   i_tick         : one-cycle frame pulse
//   o_phase_next   : phase value that holds after the current clock edge,
//                    so the parent can register its flash mask without lag
//   o_expired      : high in the cycle whose edge samples the last tick
// ----------------------------------------------------------------------------
module frame_blink_timer #(
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_FRAMES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_tick,
  output logic o_phase_next,
  output logic o_expired
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] r_frames;
  logic [BW-1:0] r_blink;
  logic          r_phase;
  logic          w_tick;
  logic          w_wrap;

  always_comb begin
    w_tick       = i_en && i_tick;
    w_wrap       = w_tick && (r_blink == BW'(BLINK_FRAMES - 1));
    o_expired    = w_tick && (r_frames == FW'(FLASH_FRAMES - 1));
    o_phase_next = i_clear ? 1'b1 : (w_wrap ? ~r_phase : r_phase);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames <= '0;
      r_blink  <= '0;
      r_phase  <= 1'b0;
    end else if (i_clear) begin
      r_frames <= '0;
      r_blink  <= '0;
      r_phase  <= 1'b1;
    end else if (w_tick) begin
      r_frames <= r_frames + 1'b1;
      r_blink  <= w_wrap ? '0 : r_blink + 1'b1;
      r_phase  <= o_phase_next;
    end
  end

endmodule

// File: rtl/line_clear_unit.sv
// ----------------------------------------------------------------------------
// line_clear_unit
// Post-lock board processor: scans the 10x20 board for full rows, blinks them
// on `flash` for FLASH_FRAMES frame ticks, collapses the board in place and
// reports the number of lines cleared.
// Ports:
//   clk, rst       : 25 MHz VGA clock, synchronous active-high reset
//   start          : piece-lock pulse, accepted only when idle
//   board_in       : board incl. locked piece, sampled on accepted start
//   frame_tick     : one pulse per video frame (used only while flashing)
//   board_out      : working board (display objectMatrix)
//   flash          : per-cell blink mask (display flash)
//   busy           : high whenever not idle
//   done           : one-cycle completion pulse
//   lines_cleared  : 0..4, valid with done and held until the next done
//   score          : running score, present only with LINE_CLEAR_SCORE_EN
// Optional feature macro: LINE_CLEAR_SCORE_EN
// ----------------------------------------------------------------------------
module line_clear_unit
  import tetris_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_FRAMES = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BOARD_BITS-1:0] board_in,
  input  logic                  frame_tick,
  output logic [BOARD_BITS-1:0] board_out,
  output logic [BOARD_BITS-1:0] flash,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0]           score
`endif
);

  lcu_state_t r_state, w_state_next;
  board_t     r_work;
  row_mask_t  r_full_mask, w_mask_next, w_mask_scan;
  logic [4:0] r_row, r_rd, r_wr;
  board_t     r_flash, w_flash_next, w_mask_cells;
  logic       r_busy, r_done, w_busy_next, w_done_next;
  logic [2:0] r_lines, w_lines_next, w_zero_rows;
  logic       w_row_full, w_clear, w_en, w_phase_next, w_expired;
  row_t       w_rows [BOARD_ROWS];

  // Row views of the working board and the full-row mask spread over cells.
  for (genvar gi = 0; gi < BOARD_ROWS; gi++) begin : g_rows
    assign w_rows[gi] = r_work[gi*BOARD_COLS +: BOARD_COLS];
    assign w_mask_cells[gi*BOARD_COLS +: BOARD_COLS] = {BOARD_COLS{w_mask_next[gi]}};
  end

  assign w_row_full  = &w_rows[r_row];
  assign w_mask_scan = r_full_mask | (row_mask_t'(w_row_full) << r_row);
  assign w_zero_rows = popcount_rows(r_full_mask);

  frame_blink_timer #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_en        (w_en),
    .i_tick      (frame_tick),
    .o_phase_next(w_phase_next),
    .o_expired   (w_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (start) w_state_next = ST_SCAN;
      ST_SCAN:     if (r_row == 5'd19)
                     w_state_next = (w_mask_scan == '0) ? ST_DONE : ST_FLASH;
      ST_FLASH:    if (w_expired) w_state_next = ST_COLLAPSE;
      ST_COLLAPSE: if (r_rd == 5'd0) w_state_next = ST_ZERO;
      ST_ZERO:     w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, derived from the
  // next state so every output lines up with the state it belongs to.
  always_comb begin
    w_mask_next = r_full_mask;
    if (r_state == ST_IDLE && start) w_mask_next = '0;
    else if (r_state == ST_SCAN)     w_mask_next = w_mask_scan;
    w_clear      = (r_state == ST_SCAN) && (w_state_next == ST_FLASH);
    w_en         = (r_state == ST_FLASH);
    w_busy_next  = (w_state_next != ST_IDLE);
    w_done_next  = (w_state_next == ST_DONE);
    w_lines_next = w_done_next ? popcount_rows(w_mask_next) : r_lines;
    w_flash_next = (w_state_next == ST_FLASH && w_phase_next) ? w_mask_cells : '0;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work      <= '0;
      r_full_mask <= '0;
      r_row       <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_flash     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_lines     <= '0;
    end else begin
      r_full_mask <= w_mask_next;
      r_flash     <= w_flash_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_lines     <= w_lines_next;
      case (r_state)
        ST_IDLE: if (start) begin
          r_work <= board_in;
          r_row  <= '0;
        end
        ST_SCAN: r_row <= (r_row == 5'd19) ? 5'd0 : r_row + 5'd1;
        ST_FLASH: if (w_expired) begin
          r_rd <= 5'd19;
          r_wr <= 5'd19;
        end
        ST_COLLAPSE: begin
          // Write pointer never passes the read pointer, so in-place is safe.
          r_rd <= r_rd - 5'd1;
          if (!r_full_mask[r_rd]) begin
            r_work[r_wr*BOARD_COLS +: BOARD_COLS] <= w_rows[r_rd];
            r_wr <= r_wr - 5'd1;
          end
        end
        ST_ZERO: begin
          for (int r = 0; r < BOARD_ROWS; r++) begin
            if (r < int'(w_zero_rows)) r_work[r*BOARD_COLS +: BOARD_COLS] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign board_out     = r_work;
  assign flash         = r_flash;
  assign busy          = r_busy;
  assign done          = r_done;
  assign lines_cleared = r_lines;

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] r_score;
  logic [16:0] w_score_sum;

  assign w_score_sum = {1'b0, r_score} + {1'b0, score_for_lines(w_lines_next)};

  always_ff @(posedge clk) begin
    if (rst)              r_score <= '0;
    else if (w_done_next) r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
  end

  assign score = r_score;
`endif

endmodule

// File: tb/tb_line_clear_unit.sv
// ----------------------------------------------------------------------------
// tb_line_clear_unit
// Directed scoreboard bench for line_clear_unit (FLASH_FRAMES=5,
// BLINK_FRAMES=2). Expected results are queued at each start; a monitor
// compares them whenever done pulses. Honours LINE_CLEAR_SCORE_EN.
// ----------------------------------------------------------------------------
module tb_line_clear_unit;
  import tetris_pkg::*;

  localparam int FF = 5;
  localparam int BF = 2;

  typedef struct {
    board_t      board;
    logic [2:0]  lines;
    logic [15:0] score;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  board_t      board_in = '0;
  board_t      board_out;
  board_t      flash;
  logic        busy;
  logic        done;
  logic [2:0]  lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score;
`endif

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_score = 16'd0;

  line_clear_unit #(.FLASH_FRAMES(FF), .BLINK_FRAMES(BF)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .board_in     (board_in),
    .frame_tick   (frame_tick),
    .board_out    (board_out),
    .flash        (flash),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score        (score)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  function automatic board_t set_row(input board_t b, input int r, input logic [9:0] v);
    board_t t;
    t = b;
    t[r*10 +: 10] = v;
    return t;
  endfunction

  // Non-full row pattern (col 9 always clear).
  function automatic logic [9:0] pat(input int r);
    return 10'((r * 41 + 3) & 'h1FF);
  endfunction

  task automatic do_start(input board_t b);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Entered at the cycle-1 negedge; checks the blink pattern through expiry.
  task automatic run_flash(input string tag, input board_t m, input bit stray);
    logic [4:0] seq;
    seq = 5'b01001;  // phase after tick 1..5: 1,0,0,1,(collapse)
    repeat (20) @(negedge clk);
    chk({tag, "_flash_entry"}, flash, m);
    if (stray) begin
      board_in = '1;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      chk({tag, "_flash_after_stray_start"}, flash, m);
    end
    for (int i = 0; i < FF; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk($sformatf("%s_flash_tick%0d", tag, i + 1), flash, seq[i] ? m : '0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 200'(busy), 200'(0));
  endtask

  // Monitor: compare queued expectations on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          $display("txn done lines=%0d board=%h", lines_cleared, board_out);
          chk("done_board", board_out, e.board);
          chk("done_lines", 200'(lines_cleared), 200'(e.lines));
`ifdef LINE_CLEAR_SCORE_EN
          chk("done_score", 200'(score), 200'(e.score));
`endif
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    board_t b, m, ex;
    bit     saw_flash;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_board_out", board_out, '0);
    chk("rst_flash", flash, '0);
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_done", 200'(done), 200'(0));
    chk("rst_lines", 200'(lines_cleared), 200'(0));
`ifdef LINE_CLEAR_SCORE_EN
    chk("rst_score", 200'(score), 200'(0));
`endif
    rst = 1'b0;

    // T1: no full rows; timing of done/busy; stray frame_tick in SCAN ignored
    b = '0;
    for (int r = 0; r < 20; r++) b = set_row(b, r, 10'h3FF ^ (10'd1 << (r % 10)));
    exp_q.push_back('{b, 3'd0, exp_score});
    do_start(b);
    saw_flash = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (flash != '0) saw_flash = 1'b1;
      if (c == 1)  chk("t1_busy_c1", 200'(busy), 200'(1));
      if (c == 20) chk("t1_done_c20", 200'(done), 200'(0));
      if (c == 21) chk("t1_done_c21", 200'(done), 200'(1));
      if (c == 22) chk("t1_busy_c22", 200'(busy), 200'(0));
      frame_tick = (c == 5);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    chk("t1_flash_never", 200'(saw_flash), 200'(0));

    // T2: row 19 full, row 18 = col 0
    b = set_row('0, 19, 10'h3FF);
    b = set_row(b, 18, 10'h001);
    m = set_row('0, 19, 10'h3FF);
    exp_score = exp_score + 16'd1;
    exp_q.push_back('{set_row('0, 19, 10'h001), 3'd1, exp_score});
    do_start(b);
    run_flash("t2", m, 1'b0);
    wait_idle("t2_idle");
    repeat (3) @(negedge clk);
    chk("t2_lines_held", 200'(lines_cleared), 200'(1));

    // T3: tetris rows 16..19, row 15 = all but col 9; stray start in FLASH
    b = '0;
    m = '0;
    for (int r = 16; r < 20; r++) begin
      b = set_row(b, r, 10'h3FF);
      m = set_row(m, r, 10'h3FF);
    end
    b = set_row(b, 15, 10'h1FF);
    exp_score = exp_score + 16'd8;
    exp_q.push_back('{set_row('0, 19, 10'h1FF), 3'd4, exp_score});
    do_start(b);
    run_flash("t3", m, 1'b1);
    wait_idle("t3_idle");

    // T4: non-contiguous full rows 10 and 12
    b = '0;
    for (int r = 0; r < 20; r++) b = set_row(b, r, pat(r));
    b = set_row(b, 10, 10'h3FF);
    b = set_row(b, 12, 10'h3FF);
    m = set_row(set_row('0, 10, 10'h3FF), 12, 10'h3FF);
    ex = '0;
    for (int k = 2; k <= 11; k++) ex = set_row(ex, k, pat(k - 2));
    ex = set_row(ex, 12, pat(11));
    for (int k = 13; k < 20; k++) ex = set_row(ex, k, pat(k));
    exp_score = exp_score + 16'd3;
    exp_q.push_back('{ex, 3'd2, exp_score});
    do_start(b);
    run_flash("t4", m, 1'b0);
    wait_idle("t4_idle");

    // T5: reset in COLLAPSE discards the clear (no done expected)
    b = set_row(set_row('0, 19, 10'h3FF), 5, 10'h0F0);
    m = set_row('0, 19, 10'h3FF);
    do_start(b);
    run_flash("t5", m, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_score = 16'd0;
    chk("t5_rst_board_out", board_out, '0);
    chk("t5_rst_flash", flash, '0);
    chk("t5_rst_busy", 200'(busy), 200'(0));
    chk("t5_rst_done", 200'(done), 200'(0));
    chk("t5_rst_lines", 200'(lines_cleared), 200'(0));
`ifdef LINE_CLEAR_SCORE_EN
    chk("t5_rst_score", 200'(score), 200'(0));
`endif
    repeat (3) @(negedge clk);

    // T6: start after reset works; row 0 full, row 1 kept in place
    b = set_row(set_row('0, 0, 10'h3FF), 1, 10'h155);
    m = set_row('0, 0, 10'h3FF);
    exp_score = exp_score + 16'd1;
    exp_q.push_back('{set_row('0, 1, 10'h155), 3'd1, exp_score});
    do_start(b);
    run_flash("t6", m, 1'b0);
    wait_idle("t6_idle");

    repeat (5) @(negedge clk);
    chk("pending_expectations", 200'(exp_q.size()), 200'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
